spike_injector: RTL and testbench
=================================

SPIKE_INJECTOR -- requirements
Module: spike_injector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14, giving the sample width; samples are two's complement with the MSB as sign.
REQ-002 SHALL have port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port i_data  input  DATA_WIDTH  clean signed sample stream.
REQ-005 SHALL have port i_valid  input  1  qualifies i_data; one sample per high cycle.
REQ-006 SHALL have port i_en  input  1  injection enable; level-sensitive.
REQ-007 SHALL have port i_period  input  16  samples from one spike start to the next.
REQ-008 SHALL have port i_width  input  8  consecutive corrupted samples per spike.
REQ-009 SHALL have port i_amplitude  input  DATA_WIDTH  spike magnitude, unsigned positive.
REQ-010 SHALL have port i_pol_mode  input  2  00 positive, 01 negative, 10 alternating (first spike positive), 11 treated as 00.
REQ-011 SHALL have port i_burst  input  8  number of spikes to emit; 0 means continuous.
REQ-012 SHALL have port o_data  output  DATA_WIDTH  sample stream, possibly corrupted.
REQ-013 SHALL have port o_valid  output  1  i_valid delayed one cycle.
REQ-014 SHALL have port o_injecting  output  1  high with o_valid when o_data is a corrupted sample.
REQ-015 SHALL have port o_done  output  1  high while in DONE.

Function
REQ-016 Output latency SHALL be exactly 1 cycle: o_data, o_valid and o_injecting are registered from the same-cycle inputs.
REQ-017 On cycles with i_valid low, o_valid SHALL go low and o_data and o_injecting SHALL hold their previous values.
REQ-018 The FSM SHALL have states IDLE, RUN and DONE.
REQ-019 IDLE->RUN SHALL occur on the first cycle i_en is high; on that entry the sample index, spike counter and polarity are cleared and i_period, i_width, i_amplitude, i_pol_mode and i_burst are snapshotted.
REQ-020 Register inputs SHALL be ignored outside that snapshot.
REQ-021 Effective width Weff SHALL be max(i_width, 1).
REQ-022 Effective period Peff SHALL be max(i_period, Weff+1), which guarantees at least one clean sample between spikes.
REQ-023 In RUN, the sample index SHALL advance only on i_valid, counting 0..Peff-1 and wrapping to 0.
REQ-024 A sample SHALL be corrupted when its index is < Weff, so the first valid sample after entry is corrupted.
REQ-025 Corrupted output SHALL be i_data ± amplitude, computed at DATA_WIDTH+2 bits and saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-026 Clean samples SHALL pass through unchanged.
REQ-027 The spike counter SHALL increment on the last corrupted sample of each spike (index Weff-1).
REQ-028 In alternating mode, polarity SHALL toggle at the same point.
REQ-029 When the burst count is nonzero and the spike counter reaches it, the FSM SHALL enter DONE.
REQ-030 The spike counter SHALL saturate at 255 in continuous mode.
REQ-031 In DONE, samples SHALL pass through clean and o_done SHALL be held high; DONE->IDLE occurs when i_en is low.
REQ-032 i_en low in RUN SHALL return the FSM to IDLE on the next edge; a sample arriving in that same cycle SHALL be output clean, and a partial spike is abandoned.
REQ-033 i_en low->high SHALL restart the sequence from index 0 with a fresh snapshot.

Reset
REQ-034 Asserting i_rst_n low SHALL immediately force: o_data=0, o_valid=0, o_injecting=0, o_done=0, FSM=IDLE, all counters 0, polarity positive, snapshot registers 0.
REQ-035 Reset asserted mid-spike SHALL abandon the spike with no residual corruption after release.

Structure
REQ-036 State encoding (IDLE/RUN/DONE) and the polarity-mode constants SHALL live in shared package iris_filter_pkg.
REQ-037 Saturating signed add/subtract SHALL be a sub-module sat_addsub, parameterized by DATA_WIDTH.
REQ-038 Target implementation size is 120-400 lines, with no memories.

Verification (DATA_WIDTH=14)
REQ-039 Constant input 100, i_valid every cycle, period=5, width=2, amp=50, mode=00, burst=3 -> outputs 150,150,100,100,100 repeated 3 times, then o_done=1 and all outputs 100.
REQ-040 Input 8000, amp=500, mode=00 -> corrupted output 8191 (saturated high); input -8000 with mode=01 -> -8192 (saturated low).
REQ-041 Mode=10, width=1, period=3, input 0, amp=10 -> output sequence 10,0,0,-10,0,0,10,...
REQ-042 Period=1, width=4 -> effective period 5 (4 corrupted samples, 1 clean); width=0 -> 1 corrupted sample per period.
REQ-043 i_valid toggling every other cycle -> index advances only on valid samples, spike positions identical in sample count, o_valid mirrors i_valid delayed by 1 cycle.
REQ-044 i_en dropped at index 1 of a spike, then reset pulsed mid-spike -> the next output is clean, state is IDLE, and o_data=0 during reset.

Source files
------------

// File: rtl/iris_filter_pkg.sv
// Shared FSM encoding, polarity-mode constants and effective-geometry helpers
// for the spike injector.
package iris_filter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [1:0] POL_POS = 2'b00;
   localparam logic [1:0] POL_NEG = 2'b01;
   localparam logic [1:0] POL_ALT = 2'b10;
   localparam logic [1:0] POL_RSV = 2'b11;

   function automatic logic [7:0] eff_width(input logic [7:0] width);
      return (width == 8'd0) ? 8'd1 : width;
   endfunction

   // Period is stretched so every spike is followed by at least one clean sample.
   function automatic logic [15:0] eff_period(input logic [15:0] period, input logic [7:0] weff);
      logic [15:0] min_period;
      min_period = {8'd0, weff} + 16'd1;
      return (period < min_period) ? min_period : period;
   endfunction

endpackage

// File: rtl/sat_addsub.sv
// Signed sample plus/minus an unsigned magnitude, computed two bits wide
// and clamped to the signed DATA_WIDTH range.
module sat_addsub #(
   parameter int DATA_WIDTH = 14
) (
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_mag,
   input  logic                  i_sub,
   output logic [DATA_WIDTH-1:0] o_y
);

   localparam logic signed [DATA_WIDTH+1:0] W_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH+1:0] W_MIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};

   logic signed [DATA_WIDTH+1:0] w_a;
   logic signed [DATA_WIDTH+1:0] w_b;
   logic signed [DATA_WIDTH+1:0] w_sum;

   assign w_a   = {{2{i_a[DATA_WIDTH-1]}}, i_a};
   assign w_b   = {2'b00, i_mag};
   assign w_sum = i_sub ? (w_a - w_b) : (w_a + w_b);

   // Clamp the widened result into the representable range.
   always_comb begin
      o_y = w_sum[DATA_WIDTH-1:0];
      if (w_sum > W_MAX) begin
         o_y = W_MAX[DATA_WIDTH-1:0];
      end else if (w_sum < W_MIN) begin
         o_y = W_MIN[DATA_WIDTH-1:0];
      end else begin
         o_y = w_sum[DATA_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/spike_injector.sv
// Periodically corrupts a signed sample stream with saturated +/- spikes of
// programmable width, period, polarity and burst count; one-cycle latency.
module spike_injector
   import iris_filter_pkg::*;
#(
   parameter int DATA_WIDTH = 14
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   input  logic                  i_en,
   input  logic [15:0]           i_period,
   input  logic [7:0]            i_width,
   input  logic [DATA_WIDTH-1:0] i_amplitude,
   input  logic [1:0]            i_pol_mode,
   input  logic [7:0]            i_burst,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_injecting,
   output logic                  o_done
);

   state_t                r_state;
   state_t                w_next_state;
   logic [15:0]           r_idx;
   logic [7:0]            r_cnt;
   logic                  r_pol;
   logic [15:0]           r_period;
   logic [7:0]            r_width;
   logic [DATA_WIDTH-1:0] r_amp;
   logic [1:0]            r_mode;
   logic [7:0]            r_burst;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_inj;

   logic [7:0]            w_weff;
   logic [15:0]           w_peff;
   logic                  w_advance;
   logic                  w_corrupt;
   logic                  w_spike_end;
   logic                  w_sub;
   logic [DATA_WIDTH-1:0] w_sat;

   assign w_weff = eff_width(r_width);
   assign w_peff = eff_period(r_period, w_weff);

   sat_addsub #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_sat_addsub (
      .i_a   (i_data),
      .i_mag (r_amp),
      .i_sub (w_sub),
      .o_y   (w_sat)
   );

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and per-sample corruption decode.
   always_comb begin
      w_next_state = r_state;
      w_advance    = 1'b0;
      w_corrupt    = 1'b0;
      w_spike_end  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_en) begin
               w_next_state = ST_RUN;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!i_en) begin
               w_next_state = ST_IDLE;
            end else if (i_valid) begin
               w_advance   = 1'b1;
               w_corrupt   = (r_idx < {8'd0, w_weff});
               w_spike_end = (r_idx == ({8'd0, w_weff} - 16'd1));
               if (w_spike_end && (r_burst != 8'd0) &&
                   (({1'b0, r_cnt} + 9'd1) == {1'b0, r_burst})) begin
                  w_next_state = ST_DONE;
               end else begin
                  w_next_state = ST_RUN;
               end
            end else begin
               w_next_state = ST_RUN;
            end
         end
         ST_DONE: begin
            if (i_en) begin
               w_next_state = ST_DONE;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Spike polarity for the current sample.
   always_comb begin
      w_sub = 1'b0;
      case (r_mode)
         POL_POS: w_sub = 1'b0;
         POL_NEG: w_sub = 1'b1;
         POL_ALT: w_sub = r_pol;
         POL_RSV: w_sub = 1'b0;
         default: w_sub = 1'b0;
      endcase
   end

   // Snapshot, sample index, spike counter and alternating polarity.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx    <= 16'd0;
         r_cnt    <= 8'd0;
         r_pol    <= 1'b0;
         r_period <= 16'd0;
         r_width  <= 8'd0;
         r_amp    <= '0;
         r_mode   <= 2'b00;
         r_burst  <= 8'd0;
      end else if ((r_state == ST_IDLE) && i_en) begin
         r_idx    <= 16'd0;
         r_cnt    <= 8'd0;
         r_pol    <= 1'b0;
         r_period <= i_period;
         r_width  <= i_width;
         r_amp    <= i_amplitude;
         r_mode   <= i_pol_mode;
         r_burst  <= i_burst;
      end else if (w_advance) begin
         r_idx <= (r_idx >= (w_peff - 16'd1)) ? 16'd0 : (r_idx + 16'd1);
         if (w_spike_end) begin
            r_cnt <= (r_cnt == 8'hFF) ? r_cnt : (r_cnt + 8'd1);
            r_pol <= (r_mode == POL_ALT) ? ~r_pol : r_pol;
         end
      end
   end

   // Registered output stage; data and flag hold across invalid cycles.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_inj   <= 1'b0;
      end else if (i_valid) begin
         r_data  <= w_corrupt ? w_sat : i_data;
         r_valid <= 1'b1;
         r_inj   <= w_corrupt;
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_injecting = r_inj;
   assign o_done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_spike_injector.sv
// Directed, self-checking bench for spike_injector at DATA_WIDTH=14.
module tb_spike_injector;

   logic               i_clk;
   logic               i_rst_n;
   logic signed [13:0] i_data;
   logic               i_valid;
   logic               i_en;
   logic [15:0]        i_period;
   logic [7:0]         i_width;
   logic [13:0]        i_amplitude;
   logic [1:0]         i_pol_mode;
   logic [7:0]         i_burst;
   logic [13:0]        o_data;
   logic               o_valid;
   logic               o_injecting;
   logic               o_done;

   int n_checks = 0;
   int n_pass   = 0;

   spike_injector #(.DATA_WIDTH(14)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_data      (i_data),
      .i_valid     (i_valid),
      .i_en        (i_en),
      .i_period    (i_period),
      .i_width     (i_width),
      .i_amplitude (i_amplitude),
      .i_pol_mode  (i_pol_mode),
      .i_burst     (i_burst),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_injecting (o_injecting),
      .o_done      (o_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Return to IDLE, then enter RUN with i_valid low so the next valid sample is index 0.
   task automatic start_run(input logic [15:0] p, input logic [7:0] w, input logic [13:0] a,
                            input logic [1:0] m, input logic [7:0] b);
      i_en = 1'b0; i_valid = 1'b0;
      step();
      i_period = p; i_width = w; i_amplitude = a; i_pol_mode = m; i_burst = b;
      i_en = 1'b1;
      step();
      i_period = 16'd999; i_width = 8'd77; i_amplitude = 14'd1234; i_pol_mode = 2'b01; i_burst = 8'd1;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_en = 1'b0; i_valid = 1'b0; i_data = 14'sd0;
      i_period = 16'd0; i_width = 8'd0; i_amplitude = 14'd0; i_pol_mode = 2'b00; i_burst = 8'd0;
      #3;
      n_checks++;
      if ({o_data, o_valid, o_injecting, o_done} !== 17'd0) $display("FAIL reset_initial: got data=%0d v=%0b inj=%0b done=%0b expected all 0", o_data, o_valid, o_injecting, o_done);
      else n_pass++;
      i_valid = 1'b1; i_data = 14'sd123; i_en = 1'b1;
      step();
      n_checks++;
      if ({o_data, o_valid, o_injecting, o_done} !== 17'd0) $display("FAIL reset_held: got data=%0d v=%0b inj=%0b done=%0b expected all 0", o_data, o_valid, o_injecting, o_done);
      else n_pass++;
      i_rst_n = 1'b1; i_en = 1'b0; i_valid = 1'b0;
      step();
   endtask

   task automatic test_burst();
      int exp_d;
      logic exp_i;
      start_run(16'd5, 8'd2, 14'd50, 2'b00, 8'd3);
      i_data = 14'sd100; i_valid = 1'b1;
      for (int k = 0; k < 18; k++) begin
         exp_i = ((k % 5) < 2) && (k < 15);
         exp_d = exp_i ? 150 : 100;
         step();
         n_checks++;
         if ($signed(o_data) !== exp_d || o_injecting !== exp_i || o_valid !== 1'b1)
            $display("FAIL burst_k%0d: got data=%0d inj=%0b v=%0b expected data=%0d inj=%0b v=1", k, $signed(o_data), o_injecting, o_valid, exp_d, exp_i);
         else n_pass++;
      end
      n_checks++;
      if (o_done !== 1'b1) $display("FAIL burst_done: got %0b expected 1", o_done);
      else n_pass++;
      i_en = 1'b0;
      step();
      n_checks++;
      if (o_done !== 1'b0) $display("FAIL done_to_idle: got %0b expected 0", o_done);
      else n_pass++;
   endtask

   task automatic test_saturation();
      start_run(16'd10, 8'd1, 14'd500, 2'b00, 8'd0);
      i_data = 14'sd8000; i_valid = 1'b1;
      step();
      n_checks++;
      if ($signed(o_data) !== 8191 || o_injecting !== 1'b1) $display("FAIL sat_high: got %0d inj=%0b expected 8191 inj=1", $signed(o_data), o_injecting);
      else n_pass++;
      start_run(16'd10, 8'd1, 14'd500, 2'b01, 8'd0);
      i_data = -14'sd8000; i_valid = 1'b1;
      step();
      n_checks++;
      if ($signed(o_data) !== -8192 || o_injecting !== 1'b1) $display("FAIL sat_low: got %0d inj=%0b expected -8192 inj=1", $signed(o_data), o_injecting);
      else n_pass++;
      step();
      n_checks++;
      if ($signed(o_data) !== -8000 || o_injecting !== 1'b0) $display("FAIL sat_clean_after: got %0d inj=%0b expected -8000 inj=0", $signed(o_data), o_injecting);
      else n_pass++;
   endtask

   task automatic test_alternating();
      int exp_seq [10] = '{10, 0, 0, -10, 0, 0, 10, 0, 0, -10};
      start_run(16'd3, 8'd1, 14'd10, 2'b10, 8'd0);
      i_data = 14'sd0; i_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         n_checks++;
         if ($signed(o_data) !== exp_seq[k]) $display("FAIL alt_k%0d: got %0d expected %0d", k, $signed(o_data), exp_seq[k]);
         else n_pass++;
      end
   endtask

   task automatic test_clamp();
      int exp_d;
      start_run(16'd1, 8'd4, 14'd50, 2'b00, 8'd0);
      i_data = 14'sd100; i_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         exp_d = ((k % 5) < 4) ? 150 : 100;
         step();
         n_checks++;
         if ($signed(o_data) !== exp_d) $display("FAIL clamp_period_k%0d: got %0d expected %0d", k, $signed(o_data), exp_d);
         else n_pass++;
      end
      start_run(16'd3, 8'd0, 14'd50, 2'b00, 8'd0);
      i_data = 14'sd100; i_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         exp_d = ((k % 3) == 0) ? 150 : 100;
         step();
         n_checks++;
         if ($signed(o_data) !== exp_d) $display("FAIL clamp_width_k%0d: got %0d expected %0d", k, $signed(o_data), exp_d);
         else n_pass++;
      end
   endtask

   task automatic test_valid_gap();
      int n = 0;
      int last_d = 0;
      logic last_i = 1'b0;
      logic v;
      start_run(16'd5, 8'd2, 14'd50, 2'b00, 8'd0);
      i_data = 14'sd100;
      for (int c = 0; c < 20; c++) begin
         v = ((c % 2) == 0);
         i_valid = v;
         step();
         if (v) begin
            last_i = ((n % 5) < 2);
            last_d = last_i ? 150 : 100;
            n++;
         end
         n_checks++;
         if (o_valid !== v || $signed(o_data) !== last_d || o_injecting !== last_i)
            $display("FAIL gap_c%0d: got v=%0b data=%0d inj=%0b expected v=%0b data=%0d inj=%0b", c, o_valid, $signed(o_data), o_injecting, v, last_d, last_i);
         else n_pass++;
      end
   endtask

   task automatic test_abort_reset();
      start_run(16'd5, 8'd3, 14'd50, 2'b00, 8'd0);
      i_data = 14'sd100; i_valid = 1'b1;
      step();
      n_checks++;
      if ($signed(o_data) !== 150) $display("FAIL abort_first: got %0d expected 150", $signed(o_data));
      else n_pass++;
      i_en = 1'b0;
      step();
      n_checks++;
      if ($signed(o_data) !== 100 || o_injecting !== 1'b0) $display("FAIL abort_en_low: got %0d inj=%0b expected 100 inj=0", $signed(o_data), o_injecting);
      else n_pass++;
      step();
      n_checks++;
      if ($signed(o_data) !== 100 || o_injecting !== 1'b0 || o_done !== 1'b0) $display("FAIL abort_idle: got %0d inj=%0b done=%0b expected 100 inj=0 done=0", $signed(o_data), o_injecting, o_done);
      else n_pass++;
      start_run(16'd5, 8'd3, 14'd50, 2'b00, 8'd0);
      i_data = 14'sd100; i_valid = 1'b1;
      step();
      step();
      n_checks++;
      if ($signed(o_data) !== 150 || o_injecting !== 1'b1) $display("FAIL restart_spike: got %0d inj=%0b expected 150 inj=1", $signed(o_data), o_injecting);
      else n_pass++;
      i_rst_n = 1'b0;
      #2;
      n_checks++;
      if ({o_data, o_valid, o_injecting, o_done} !== 17'd0) $display("FAIL reset_mid_spike: got data=%0d v=%0b inj=%0b done=%0b expected all 0", o_data, o_valid, o_injecting, o_done);
      else n_pass++;
      i_en = 1'b0;
      #2;
      i_rst_n = 1'b1;
      step();
      n_checks++;
      if ($signed(o_data) !== 100 || o_injecting !== 1'b0 || o_valid !== 1'b1) $display("FAIL after_reset: got %0d inj=%0b v=%0b expected 100 inj=0 v=1", $signed(o_data), o_injecting, o_valid);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_burst();
      test_saturation();
      test_alternating();
      test_clamp();
      test_valid_gap();
      test_abort_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
